// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC and EPC registers and arbitrates
// between sequential advance, stall, redirect, interrupt entry, RTI and HALT.
module pc_sequencer #(
    parameter int                 WIDTH      = 16,
    parameter logic [WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [WIDTH-1:0]   IRQ_VECTOR = WIDTH'(16'h1000),
    parameter int                 INC        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_pc,
    input  logic             irq,
    input  logic             rti,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] epc,
    output logic             in_isr,
    output logic             halted,
    output logic             flush
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ISR    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             flush_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    // Truncating add gives the modulo-2^WIDTH wrap with no carry out.
    assign pc_inc = pc_q + INC_W;

    // Priority chain: only the first matching event acts; HALTED ignores all.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        flush_d = 1'b0;
        if (state_q != ST_HALTED) begin
            if (rti && (state_q == ST_ISR)) begin
                pc_d    = epc_q;
                state_d = ST_RUN;
                flush_d = 1'b1;
            end else if (redir_valid) begin
                pc_d    = redir_pc;
                flush_d = 1'b1;
            end else if (irq && (state_q == ST_RUN) && !stall) begin
                epc_d   = pc_q;
                pc_d    = IRQ_VECTOR;
                state_d = ST_ISR;
                flush_d = 1'b1;
            end else if (halt) begin
                state_d = ST_HALTED;
            end else if (!stall) begin
                pc_d = pc_inc;
            end
        end
    end

    assign flush  = flush_d && !rst;
    assign pc     = pc_q;
    assign epc    = epc_q;
    assign in_isr = (state_q == ST_ISR);
    assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        irq;
    logic        rti;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] epc;
    logic        in_isr;
    logic        halted;
    logic        flush;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    pc_sequencer #(
        .WIDTH      (16),
        .RESET_PC   (16'h0000),
        .IRQ_VECTOR (16'h1000),
        .INC        (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .irq         (irq),
        .rti         (rti),
        .halt        (halt),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .epc         (epc),
        .in_isr      (in_isr),
        .halted      (halted),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Advance one edge, then settle outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        $display("cycle %0d: rst=%0b stall=%0b redir=%0b irq=%0b rti=%0b halt=%0b -> pc=0x%04h epc=0x%04h isr=%0b halted=%0b",
                 cycle, rst, stall, redir_valid, irq, rti, halt, pc, epc, in_isr, halted);
    endtask

    task automatic idle();
        stall = 0; redir_valid = 0; redir_pc = 16'h0; irq = 0; rti = 0; halt = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        redir_valid = 1; redir_pc = 16'h0123;
        #1;
        check("flush_in_reset", flush, 0);
        tick();
        tick();
        check("rst_pc", pc, 16'h0000);
        check("rst_epc", epc, 16'h0000);
        check("rst_isr", in_isr, 0);
        check("rst_halted", halted, 0);
        rst = 0;
        idle();
        #1;
        check("first_fetch_pc", pc, 16'h0000);
        check("seq_flush", flush, 0);
        check("pc_inc0", pc_inc, 16'h0002);
        tick(); check("seq_pc1", pc, 16'h0002);
        tick(); check("seq_pc2", pc, 16'h0004);
        tick(); check("seq_pc3", pc, 16'h0006);

        // stall holds, redirect overrides stall
        stall = 1;
        tick(); check("stall_pc1", pc, 16'h0006);
        tick(); check("stall_pc2", pc, 16'h0006);
        redir_valid = 1; redir_pc = 16'h0040;
        #1; check("redir_flush", flush, 1);
        tick(); check("redir_pc", pc, 16'h0040);

        // interrupt round trip
        idle(); redir_valid = 1; redir_pc = 16'h0010;
        tick(); check("goto_10", pc, 16'h0010);
        idle(); irq = 1;
        #1; check("irq_flush", flush, 1);
        tick();
        check("irq_pc", pc, 16'h1000);
        check("irq_epc", epc, 16'h0010);
        check("irq_isr", in_isr, 1);
        #1; check("isr_noflush", flush, 0);
        tick(); check("isr_pc1", pc, 16'h1002);
        tick(); check("isr_pc2", pc, 16'h1004);
        tick(); check("isr_pc3", pc, 16'h1006);
        check("isr_epc_hold", epc, 16'h0010);
        irq = 0; rti = 1;
        #1; check("rti_flush", flush, 1);
        tick();
        check("rti_pc", pc, 16'h0010);
        check("rti_isr", in_isr, 0);

        // simultaneous irq + redirect: redirect wins, irq deferred
        idle(); irq = 1; redir_valid = 1; redir_pc = 16'h0080;
        tick();
        check("simul_pc", pc, 16'h0080);
        check("simul_isr", in_isr, 0);
        redir_valid = 0;
        tick();
        check("defer_pc", pc, 16'h1000);
        check("defer_epc", epc, 16'h0080);
        irq = 0; rti = 1;
        tick(); check("ret80_pc", pc, 16'h0080);
        #1; check("rti_run_noflush", flush, 0);
        tick(); check("rti_run_ignored", pc, 16'h0082);

        // irq deferred by stall
        idle(); irq = 1; stall = 1;
        #1; check("irq_stall_noflush", flush, 0);
        tick();
        check("irq_stall_pc", pc, 16'h0082);
        check("irq_stall_isr", in_isr, 0);
        stall = 0;
        tick(); check("irq_after_stall_pc", pc, 16'h1000);
        check("irq_after_stall_epc", epc, 16'h0082);
        // level held across RTI re-enters on the next RUN cycle
        rti = 1;
        tick(); check("rti_level_pc", pc, 16'h0082);
        check("rti_level_isr", in_isr, 0);
        rti = 0;
        tick(); check("reentry_pc", pc, 16'h1000);
        check("reentry_isr", in_isr, 1);
        irq = 0; rti = 1;
        tick(); check("ret82_pc", pc, 16'h0082);

        // halt freezes everything until reset
        idle(); redir_valid = 1; redir_pc = 16'h0020;
        tick(); check("goto_20", pc, 16'h0020);
        idle(); halt = 1; stall = 1;
        #1; check("halt_noflush", flush, 0);
        tick();
        check("halt_pc", pc, 16'h0020);
        check("halt_flag", halted, 1);
        idle(); irq = 1; rti = 1; redir_valid = 1; redir_pc = 16'h0300;
        for (int i = 0; i < 5; i++) begin
            #1; check("halted_flush", flush, 0);
            tick();
            check("halted_pc", pc, 16'h0020);
            check("halted_epc", epc, 16'h0082);
            check("halted_stay", halted, 1);
        end
        rst = 1;
        tick();
        check("halt_rst_pc", pc, 16'h0000);
        check("halt_rst_flag", halted, 0);

        // wrap at the top of the address space
        rst = 0; idle(); redir_valid = 1; redir_pc = 16'hFFFE;
        tick(); check("wrap_pc", pc, 16'hFFFE);
        check("wrap_inc", pc_inc, 16'h0000);
        idle();
        tick(); check("wrap_next", pc, 16'h0000);
        check("wrap_inc2", pc_inc, 16'h0002);

        // reset in the middle of an ISR
        tick(); check("pre_isr_pc", pc, 16'h0002);
        irq = 1;
        tick(); check("isr2_isr", in_isr, 1);
        check("isr2_epc", epc, 16'h0002);
        rst = 1;
        #1; check("rst_isr_flush", flush, 0);
        tick();
        check("isr_rst_isr", in_isr, 0);
        check("isr_rst_epc", epc, 16'h0000);
        check("isr_rst_pc", pc, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised fetch-stage PC sequencer. It is the registered successor to the combinational next-PC selector: it owns the PC register and arbitrates between sequential advance, fetch stall, branch/jump redirect, interrupt entry, RTI return and HALT. It holds the exception PC (EPC) and a small RUN/ISR/HALTED state machine. It sits between the execute-stage branch resolution logic and the instruction memory address port.

## Interface
Parameters:
- WIDTH, 16, PC/address width in bits
- RESET_PC, 0, PC value loaded on reset
- IRQ_VECTOR, 16'h1000, PC loaded on interrupt entry (WIDTH bits)
- INC, 2, sequential increment (bytes per instruction)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  fetch stall; hold PC
- redir_valid  in  1  taken branch/jump resolved this cycle
- redir_pc  in  WIDTH  redirect target
- irq  in  1  level-sensitive interrupt request
- rti  in  1  return-from-interrupt executed
- halt  in  1  HALT instruction decoded
- pc  out  WIDTH  current fetch PC (registered)
- pc_inc  out  WIDTH  pc + INC, combinational, modulo 2^WIDTH
- epc  out  WIDTH  saved interrupt return PC (registered)
- in_isr  out  1  state == ISR
- halted  out  1  state == HALTED
- flush  out  1  combinational; high in any cycle where the next PC is non-sequential because of redirect, IRQ entry or RTI

## Operation
- States: RUN, ISR, HALTED. Reset: state=RUN, pc=RESET_PC, epc=0, in_isr=0, halted=0. flush=0 while rst=1.
- Per-cycle priority in RUN/ISR, highest first. Only the first matching event acts:
  1. rti with state==ISR: pc<=epc, state<=RUN, flush=1. rti in RUN is ignored and falls through to lower priorities.
  2. redir_valid: pc<=redir_pc, flush=1. This overrides stall.
  3. irq with state==RUN and stall==0: epc<=pc, pc<=IRQ_VECTOR, state<=ISR, flush=1.
  4. halt: pc held, state<=HALTED.
  5. stall: pc held.
  6. Otherwise pc<=pc_inc.
- irq while in ISR is not accepted (no nesting). A level still high after RTI is taken on the first eligible cycle in RUN.
- irq blocked by stall, redirect or rti is deferred, not lost, as long as it is held.
- HALTED: pc and epc frozen. All inputs except rst are ignored. flush=0. Exit only via rst.
- Arithmetic: pc_inc = (pc + INC) mod 2^WIDTH. 0xFFFE + 2 = 0x0000 at WIDTH=16, with no error flag.
- rst asserted in any state, including mid-ISR or HALTED, forces the reset values on the next edge.

## Timing
- pc, epc, in_isr and halted are registered. An event sampled at edge N is visible after edge N.
- pc_inc and flush are combinational from the current pc, state and inputs. Zero-cycle latency.
- Redirect latency: redir_valid high in cycle N gives pc=redir_pc in cycle N+1.
- IRQ entry: one cycle. EPC captures the pc present in the accepting cycle, which is re-fetched after RTI.
- The first fetch after reset deassertion uses RESET_PC. Advance starts on the following edge.

## Test plan
- Reset/sequential: rst=1 for 2 cycles, then 0 -> pc=0x0000, 0x0002, 0x0004, 0x0006; epc=0, in_isr=0, halted=0, flush=0.
- Stall vs redirect: at pc=0x0006, stall=1 for 2 cycles -> pc stays 0x0006. Then stall=1, redir_valid=1, redir_pc=0x0040 -> flush=1, next pc=0x0040.
- Interrupt round trip: at pc=0x0010 assert irq -> next pc=0x1000, epc=0x0010, in_isr=1. Keep irq high for 3 cycles -> pc=0x1002, 0x1004, 0x1006 with no re-entry. Drop irq, assert rti -> pc=0x0010, in_isr=0.
- Simultaneous events: irq=1 with redir_valid=1, redir_pc=0x0080 -> pc=0x0080, in_isr=0. Next cycle -> pc=0x1000, epc=0x0080. rti while in RUN -> ignored, pc advances by 2.
- Halt: halt=1 at pc=0x0020 -> pc frozen at 0x0020, halted=1. irq, redir_valid and rti are then ignored for 5 cycles. rst -> pc=0x0000, halted=0.
- Wrap: redirect to 0xFFFE -> next pc=0x0000, pc_inc=0x0002. rst asserted while in_isr=1 -> in_isr=0, epc=0.
